dfe_out_buffer: RTL

Output buffering stage that sits directly downstream of the DFE filter-array top level. It captures each valid output sample together with its overflow/underflow flags into a synchronous FIFO. It presents the samples to the downstream consumer over a valid/ready handshake and keeps saturating event counters for dropped samples and saturation events. This decouples the fixed-rate filter chain output from a consumer that may stall.

---
 rtl/dfe_out_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/dfe_out_buffer.sv
// dfe_out_buffer
//   Output buffer behind the DFE filter array. Each valid sample is captured
//   with its overflow/underflow flags into a synchronous show-ahead FIFO. The
//   FIFO is drained over a valid/ready handshake. Saturating counters track
//   dropped samples and saturation events.
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   valid_in, core_in          sample strobe and signed sample from the filter chain
//   overflow_in, underflow_in  saturation flags, qualified by valid_in
//   flush                      pulse: empty the FIFO; counters are untouched
//   clr_cnt                    pulse: clear drop_cnt and sat_cnt
//   m_ready/m_valid            downstream handshake
//   m_data/m_flags             head sample and its {overflow, underflow} flags
//   level, full, empty         registered occupancy
//   drop_cnt                   samples lost to a full FIFO (saturating)
//   sat_cnt                    flagged valid_in cycles (saturating)
module dfe_out_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        core_in,
  input  logic                         overflow_in,
  input  logic                         underflow_in,
  input  logic                         flush,
  input  logic                         clr_cnt,
  input  logic                         m_ready,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [1:0]                   m_flags,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic [CNT_WIDTH-1:0]         sat_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            level_q, level_nxt;
  logic                     full_q, empty_q;
  logic                     pop, push, drop, sat_ev;

  // When full, a same-cycle pop frees the slot, so the push is accepted.
  assign pop    = !empty_q && m_ready && !flush;
  assign push   = valid_in && (!full_q || pop) && !flush;
  assign drop   = valid_in && full_q && !pop && !flush;
  assign sat_ev = valid_in && (overflow_in || underflow_in);

  always_comb begin
    level_nxt = level_q;
    if (flush) level_nxt = '0;
    else       level_nxt = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) mem[wr_ptr] <= {overflow_in, underflow_in, core_in};
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level_q <= level_nxt;
      full_q  <= (level_nxt == FULL_LVL);
      empty_q <= (level_nxt == '0);
    end
  end

  // Clear beats increment; both counters stick at all ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      drop_cnt <= '0;
      sat_cnt  <= '0;
    end else begin
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (sat_ev && !(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
    end
  end

  // Show-ahead: the head entry is always presented.
  assign m_valid = !empty_q;
  assign m_data  = mem[rd_ptr][DATA_WIDTH-1:0];
  assign m_flags = mem[rd_ptr][EW-1 -: 2];
  assign level   = level_q;
  assign full    = full_q;
  assign empty   = empty_q;
endmodule
